// File: rtl/fetch_queue.sv
// fetch_queue: fetch-PC register feeding a circular {instr, pc} queue with flush/mispredict redirect.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       ihit,
  input  logic [31:0]                imemload,
  input  logic [31:0]                pc_prediction,
  input  logic                       misprediction,
  input  logic [31:0]                correct_target,
  input  logic                       flush,
  input  logic [31:0]                correct_pc,
  input  logic                       stall,
  input  logic                       dispatch_free,
  output logic                       imemREN,
  output logic [31:0]                imemaddr,
  output logic [31:0]                instr,
  output logic [31:0]                pc,
  output logic                       instr_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   fetch_pc;
  logic [AW-1:0] head, tail;
  logic          full, redirect, push, pop;
  always_comb begin
    redirect    = flush || misprediction;
    full        = count == CW'(DEPTH);
    instr_valid = count != '0;
    imemREN     = !full && !stall && !redirect;
    imemaddr    = fetch_pc;
    push        = imemREN && ihit;
    pop         = instr_valid && dispatch_free && !stall && !redirect;
    instr       = instr_valid ? instr_mem[head] : 32'h0;
    pc          = instr_valid ? pc_mem[head] : 32'h0;
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= flush ? correct_pc : correct_target;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= pc_prediction;
        tail     <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // Storage needs no reset: empty-queue outputs are masked to zero above.
  always_ff @(posedge CLK) begin
    if (push) begin
      instr_mem[tail] <= imemload;
      pc_mem[tail]    <= fetch_pc;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vectors for fetch_queue (DEPTH=4, RESET_PC=0).
module tb_fetch_queue;
  logic        CLK = 0, nRST = 0;
  logic        ihit = 0, misprediction = 0, flush = 0, stall = 0, dispatch_free = 0;
  logic [31:0] imemload = 0, pc_prediction = 0, correct_target = 0, correct_pc = 0;
  logic        imemREN, instr_valid;
  logic [31:0] imemaddr, instr, pc;
  logic [2:0]  count;
  int          total = 0, bad = 0;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .pc_prediction(pc_prediction), .misprediction(misprediction),
    .correct_target(correct_target), .flush(flush), .correct_pc(correct_pc),
    .stall(stall), .dispatch_free(dispatch_free), .imemREN(imemREN),
    .imemaddr(imemaddr), .instr(instr), .pc(pc), .instr_valid(instr_valid),
    .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_addr", imemaddr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", pc, 0);
    step();
    nRST = 1;
    chk("rel_ren", 32'(imemREN), 1);
    // pop on empty queue is ignored
    dispatch_free = 1;
    step();
    chk("empty_pop_count", 32'(count), 0);
    chk("empty_pop_addr", imemaddr, 32'h0);
    // first fetch, one-cycle latency
    dispatch_free = 0; ihit = 1; imemload = 32'h1000; pc_prediction = 32'h4;
    step();
    chk("lat_instr", instr, 32'h1000);
    chk("lat_pc", pc, 32'h0);
    chk("lat_addr", imemaddr, 32'h4);
    chk("lat_count", 32'(count), 1);
    // fill to saturation; pushes at 4,8,12 then two ignored hits
    imemload = 32'h1004; pc_prediction = 32'h8;  step(); chk("fill_cnt2", 32'(count), 2);
    imemload = 32'h1008; pc_prediction = 32'hC;  step(); chk("fill_cnt3", 32'(count), 3);
    imemload = 32'h100C; pc_prediction = 32'h10; step(); chk("fill_cnt4", 32'(count), 4);
    chk("full_ren", 32'(imemREN), 0);
    imemload = 32'hDEAD; pc_prediction = 32'h99; step();
    imemload = 32'hBEEF; pc_prediction = 32'h77; step();
    chk("full_count", 32'(count), 4);
    chk("full_addr", imemaddr, 32'h10);
    chk("full_ren2", 32'(imemREN), 0);
    chk("full_head", instr, 32'h1000);
    // single pop
    ihit = 0; dispatch_free = 1;
    step();
    chk("pop_count", 32'(count), 3);
    chk("pop_instr", instr, 32'h1004);
    chk("pop_pc", pc, 32'h4);
    // simultaneous push+pop, pointers wrap
    ihit = 1;
    for (int k = 1; k <= 8; k++) begin
      imemload = 32'h1000 | (32'h10 + 32'(4 * (k - 1)));
      pc_prediction = 32'h10 + 32'(4 * k);
      step();
      chk("pp_count", 32'(count), 3);
      chk("pp_pc", pc, 32'(4 + 4 * k));
      chk("pp_instr", instr, 32'h1000 | 32'(4 + 4 * k));
    end
    chk("pp_addr", imemaddr, 32'h30);
    // misprediction with same-cycle ihit
    misprediction = 1; correct_target = 32'h80; imemload = 32'hBAD0; pc_prediction = 32'h55;
    #1 chk("mp_ren", 32'(imemREN), 0);
    step();
    chk("mp_count", 32'(count), 0);
    chk("mp_valid", 32'(instr_valid), 0);
    chk("mp_addr", imemaddr, 32'h80);
    chk("mp_instr", instr, 0);
    misprediction = 0; ihit = 0; dispatch_free = 0;
    #1 chk("mp_resume", 32'(imemREN), 1);
    // two entries, then stall
    ihit = 1; imemload = 32'h2080; pc_prediction = 32'h84; step();
    imemload = 32'h2084; pc_prediction = 32'h88; step();
    chk("st_pre", 32'(count), 2);
    stall = 1; dispatch_free = 1; imemload = 32'hBAD1; pc_prediction = 32'h66;
    #1 chk("st_ren", 32'(imemREN), 0);
    step();
    chk("st_count", 32'(count), 2);
    chk("st_addr", imemaddr, 32'h88);
    chk("st_pc", pc, 32'h80);
    chk("st_instr", instr, 32'h2080);
    // flush beats misprediction, and stall does not block it
    flush = 1; correct_pc = 32'h200; misprediction = 1; correct_target = 32'h80;
    step();
    chk("fl_addr", imemaddr, 32'h200);
    chk("fl_count", 32'(count), 0);
    flush = 0; misprediction = 0; stall = 0; dispatch_free = 0;
    // async reset mid-stream
    imemload = 32'h3000; pc_prediction = 32'h204; step();
    imemload = 32'h3004; pc_prediction = 32'h208; step();
    chk("ar_pre", 32'(count), 2);
    ihit = 0;
    #2 nRST = 0;
    #1;
    chk("ar_count", 32'(count), 0);
    chk("ar_valid", 32'(instr_valid), 0);
    chk("ar_instr", instr, 0);
    chk("ar_pc", pc, 0);
    chk("ar_addr", imemaddr, 32'h0);
    step();
    nRST = 1;
    step();
    chk("ar_rel_addr", imemaddr, 32'h0);
    chk("ar_rel_ren", 32'(imemREN), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
